// File: rtl/complex_mult_pipe.sv
// Purpose : pipelined complex multiply x*nco or x*conj(nco), with a shift/saturate narrowing stage.
// Latency : 3 cycles from input accept to valid_o while ready_i stays high; one sample per cycle.
// Backpr. : all stages advance together when ready_i | ~valid_o; ready_o mirrors that advance term.
//
// Ports   : clk, rst (async active-low)
//           real_i/imag_i/nco_cos/nco_sin [W_IN] signed, conj_i, valid_i -> ready_o
//           res_yreal/res_yimag [W_OUT] signed, valid_o, sat_o <- ready_i
//           sat_cnt_o [16] saturating count of accepted saturated results
// Options : define CMULT_ROUND_EN to round half up before the SHIFT (default: truncate).
module complex_mult_pipe #(
  parameter int W_IN  = 8,
  parameter int W_OUT = 16,
  parameter int SHIFT = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [W_IN-1:0]   real_i,
  input  logic [W_IN-1:0]   imag_i,
  input  logic [W_IN-1:0]   nco_cos,
  input  logic [W_IN-1:0]   nco_sin,
  input  logic              conj_i,
  input  logic              valid_i,
  output logic              ready_o,
  output logic [W_OUT-1:0]  res_yreal,
  output logic [W_OUT-1:0]  res_yimag,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              sat_o,
  output logic [15:0]       sat_cnt_o
);

  localparam int WP = 2 * W_IN;      // product width
  localparam int WS = WP + 1;        // sum width
  localparam int WR = WS + 1;        // one guard bit so the rounding add cannot wrap
  localparam int WC = (WR > W_OUT + 1) ? WR : W_OUT + 1;  // compare width, always wider than output

  localparam logic signed [WC-1:0] SAT_MAX = {{(WC-W_OUT+1){1'b0}}, {(W_OUT-1){1'b1}}};
  localparam logic signed [WC-1:0] SAT_MIN = {{(WC-W_OUT+1){1'b1}}, {(W_OUT-1){1'b0}}};
`ifdef CMULT_ROUND_EN
  localparam logic signed [WC-1:0] RND = (SHIFT > 0) ? (WC'(1) <<< (SHIFT > 0 ? SHIFT - 1 : 0)) : '0;
`else
  localparam logic signed [WC-1:0] RND = '0;
`endif

  // A single advance term keeps every stage in lockstep, so a stall never splits a sample.
  logic advance;
  assign advance = ready_i | ~valid_o;
  assign ready_o = advance;

  // ---------------- stage 1: products ----------------
  logic signed [WP-1:0] re_x, im_x, cos_x, sin_x;
  assign re_x  = {{W_IN{real_i[W_IN-1]}},  real_i};
  assign im_x  = {{W_IN{imag_i[W_IN-1]}},  imag_i};
  assign cos_x = {{W_IN{nco_cos[W_IN-1]}}, nco_cos};
  assign sin_x = {{W_IN{nco_sin[W_IN-1]}}, nco_sin};

  logic signed [WP-1:0] p_rc, p_is, p_ic, p_rs;
  logic                 conj1, v1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p_rc  <= '0;
      p_is  <= '0;
      p_ic  <= '0;
      p_rs  <= '0;
      conj1 <= 1'b0;
      v1    <= 1'b0;
    end else if (advance) begin
      p_rc  <= re_x * cos_x;
      p_is  <= im_x * sin_x;
      p_ic  <= im_x * cos_x;
      p_rs  <= re_x * sin_x;
      conj1 <= conj_i;
      v1    <= valid_i;
    end
  end

  // ---------------- stage 2: sums ----------------
  logic signed [WS-1:0] rc_e, is_e, ic_e, rs_e, sum_r_c, sum_i_c;
  assign rc_e = {p_rc[WP-1], p_rc};
  assign is_e = {p_is[WP-1], p_is};
  assign ic_e = {p_ic[WP-1], p_ic};
  assign rs_e = {p_rs[WP-1], p_rs};

  // Conjugating the oscillator only flips the sign of the sin terms.
  assign sum_r_c = conj1 ? (rc_e + is_e) : (rc_e - is_e);
  assign sum_i_c = conj1 ? (ic_e - rs_e) : (ic_e + rs_e);

  logic signed [WS-1:0] sum_r, sum_i;
  logic                 v2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sum_r <= '0;
      sum_i <= '0;
      v2    <= 1'b0;
    end else if (advance) begin
      sum_r <= sum_r_c;
      sum_i <= sum_i_c;
      v2    <= v1;
    end
  end

  // ---------------- stage 3: shift, saturate ----------------
  // Returns {saturated, narrowed value}.
  function automatic logic [W_OUT:0] narrow(input logic signed [WS-1:0] sum);
    logic signed [WC-1:0] x;
    x = {{(WC-WS){sum[WS-1]}}, sum};
    x = x + RND;
    x = x >>> SHIFT;
    if (x > SAT_MAX)
      narrow = {1'b1, 1'b0, {(W_OUT-1){1'b1}}};
    else if (x < SAT_MIN)
      narrow = {1'b1, 1'b1, {(W_OUT-1){1'b0}}};
    else
      narrow = {1'b0, x[W_OUT-1:0]};
  endfunction

  logic [W_OUT:0] nr_r, nr_i;
  assign nr_r = narrow(sum_r);
  assign nr_i = narrow(sum_i);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res_yreal <= '0;
      res_yimag <= '0;
      sat_o     <= 1'b0;
      valid_o   <= 1'b0;
    end else if (advance) begin
      res_yreal <= nr_r[W_OUT-1:0];
      res_yimag <= nr_i[W_OUT-1:0];
      sat_o     <= nr_r[W_OUT] | nr_i[W_OUT];
      valid_o   <= v2;
    end
  end

  // Counts saturated results only when they actually leave the block.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sat_cnt_o <= '0;
    end else if (valid_o && ready_i && sat_o && (sat_cnt_o != 16'hFFFF)) begin
      sat_cnt_o <= sat_cnt_o + 16'd1;
    end
  end

endmodule

// File: tb/tb_complex_mult_pipe.sv
module tb_complex_mult_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [7:0]  re, im, co, si;
  logic        conj, vld, rdy_a;
  logic        b_rdy_i = 1'b1;

  logic        a_rdy, a_vld, a_sat;
  logic [15:0] a_yr, a_yi, a_cnt;
  logic        b_rdy, b_vld, b_sat;
  logic [7:0]  b_yr, b_yi;
  logic [15:0] b_cnt;

  // Instance A: default parameters, backpressure driven by the bench.
  complex_mult_pipe u_a (
    .clk(clk), .rst(rst),
    .real_i(re), .imag_i(im), .nco_cos(co), .nco_sin(si),
    .conj_i(conj), .valid_i(vld), .ready_o(a_rdy),
    .res_yreal(a_yr), .res_yimag(a_yi), .valid_o(a_vld),
    .ready_i(rdy_a), .sat_o(a_sat), .sat_cnt_o(a_cnt)
  );

  // Instance B: narrow output with a shift, so saturation and rounding are reachable.
  complex_mult_pipe #(.W_IN(8), .W_OUT(8), .SHIFT(1)) u_b (
    .clk(clk), .rst(rst),
    .real_i(re), .imag_i(im), .nco_cos(co), .nco_sin(si),
    .conj_i(conj), .valid_i(vld), .ready_o(b_rdy),
    .res_yreal(b_yr), .res_yimag(b_yi), .valid_o(b_vld),
    .ready_i(b_rdy_i), .sat_o(b_sat), .sat_cnt_o(b_cnt)
  );

  typedef struct {
    int yr;
    int yi;
    bit sat;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;
  int   n_chk = 0;
  int   n_err = 0;
  int   cnt_a = 0;
  int   cnt_b = 0;

  task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s got %0d want %0d", tag, got, want);
    end
  endtask

  // Reference: full-precision complex product, then shift/round and clamp to the output range.
  function automatic int narrow_m(input longint v_in, input int wout, input int sh, output bit f);
    longint v, hi, lo;
    v = v_in;
`ifdef CMULT_ROUND_EN
    if (sh > 0) v = v + (longint'(1) << (sh - 1));
`endif
    v  = v >>> sh;
    hi = (longint'(1) << (wout - 1)) - 1;
    lo = -(longint'(1) << (wout - 1));
    f  = 1'b0;
    if (v > hi) begin f = 1'b1; v = hi; end
    else if (v < lo) begin f = 1'b1; v = lo; end
    return int'(v);
  endfunction

  function automatic exp_t model(input logic [7:0] r, input logic [7:0] i, input logic [7:0] c,
                                 input logic [7:0] s, input bit cj, input int wout, input int sh);
    exp_t   e;
    longint rr, ii, cc, ss, yr, yi;
    bit     fr, fi;
    rr = longint'($signed(r));
    ii = longint'($signed(i));
    cc = longint'($signed(c));
    ss = longint'($signed(s));
    yr = cj ? (rr * cc + ii * ss) : (rr * cc - ii * ss);
    yi = cj ? (ii * cc - rr * ss) : (ii * cc + rr * ss);
    e.yr  = narrow_m(yr, wout, sh, fr);
    e.yi  = narrow_m(yi, wout, sh, fi);
    e.sat = fr | fi;
    return e;
  endfunction

  // Scoreboards: handshakes are decided on the coming rising edge, so look at negedge.
  always @(negedge clk) begin
    if (rst) begin
      if (vld && a_rdy) qa.push_back(model(re, im, co, si, conj, 16, 0));
      if (vld && b_rdy) qb.push_back(model(re, im, co, si, conj, 8, 1));
      if (a_vld && rdy_a) begin
        if (qa.size() == 0) chk("a_extra", 1, 0);
        else begin
          ea = qa.pop_front();
          chk("a_yr", $signed(a_yr), ea.yr);
          chk("a_yi", $signed(a_yi), ea.yi);
          chk("a_sat", a_sat, ea.sat);
          chk("a_cnt", a_cnt, cnt_a);
          if (ea.sat && cnt_a < 65535) cnt_a++;
        end
      end
      if (b_vld && b_rdy_i) begin
        if (qb.size() == 0) chk("b_extra", 1, 0);
        else begin
          eb = qb.pop_front();
          chk("b_yr", $signed(b_yr), eb.yr);
          chk("b_yi", $signed(b_yi), eb.yi);
          chk("b_sat", b_sat, eb.sat);
          chk("b_cnt", b_cnt, cnt_b);
          if (eb.sat && cnt_b < 65535) cnt_b++;
        end
      end
    end
  end

  task automatic set_in(input int r, input int i, input int c, input int s, input bit cj);
    re = r[7:0]; im = i[7:0]; co = c[7:0]; si = s[7:0]; conj = cj;
  endtask

  task automatic set_rand();
    set_in(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
           int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), bit'($urandom_range(0, 1)));
  endtask

  // Present one sample and hold it until instance A takes it.
  task automatic send(input int r, input int i, input int c, input int s, input bit cj);
    bit acc;
    acc = 1'b0;
    set_in(r, i, c, s, cj);
    vld = 1'b1;
    for (int k = 0; k < 200 && !acc; k++) begin
      @(negedge clk);
      acc = a_rdy;
      @(posedge clk); #1;
    end
    if (!acc) chk("send_timeout", 0, 1);
    vld = 1'b0;
  endtask

  int lat, idx;
  bit got, acc;
  logic [15:0] hold_yr, hold_yi;
  int s_r[10], s_i[10], s_c[10], s_s[10];
  bit s_cj[10];

  initial begin
    rst = 1'b0; vld = 1'b0; rdy_a = 1'b0;
    set_in(0, 0, 0, 0, 1'b0);
    #12;
    chk("rst_vld", a_vld, 0);
    chk("rst_sat", a_sat, 0);
    chk("rst_yr", a_yr, 0);
    chk("rst_yi", a_yi, 0);
    chk("rst_cnt", a_cnt, 0);
    chk("rst_b_vld", b_vld, 0);
    chk("rst_b_cnt", b_cnt, 0);

    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("rdy_after_rst", a_rdy, 1);
    rdy_a = 1'b1;

    // First-sample latency with the basic vector.
    set_in(3, 4, 5, -2, 1'b0);
    vld = 1'b1;
    lat = 0; got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(posedge clk); #1;
      vld = 1'b0;
      lat++;
      got = a_vld;
    end
    chk("latency", lat, 3);
    chk("lat_sat", a_sat, 0);

    // Directed corner vectors; values checked by the scoreboards.
    send(3, 4, 5, -2, 1'b1);
    send(-128, -128, -128, 127, 1'b0);
    send(-128, 127, -128, -128, 1'b1);
    send(-128, -128, -128, -128, 1'b0);
    send(127, 127, 127, -128, 1'b1);
    send(5, 0, 1, 0, 1'b0);
    send(-5, 0, 1, 0, 1'b0);
    send(3, 0, 1, 0, 1'b0);
    send(-3, 0, 1, 0, 1'b0);
    repeat (6) begin @(posedge clk); #1; end

    // Ten-sample stream with a four-cycle downstream stall.
    for (int k = 0; k < 10; k++) begin
      s_r[k] = int'($urandom_range(0, 255)); s_i[k] = int'($urandom_range(0, 255));
      s_c[k] = int'($urandom_range(0, 255)); s_s[k] = int'($urandom_range(0, 255));
      s_cj[k] = bit'($urandom_range(0, 1));
    end
    idx = 0;
    for (int k = 0; k < 24; k++) begin
      rdy_a = !(k >= 4 && k <= 7);
      if (idx < 10) begin
        set_in(s_r[idx], s_i[idx], s_c[idx], s_s[idx], s_cj[idx]);
        vld = 1'b1;
      end else vld = 1'b0;
      @(negedge clk);
      if (k >= 4 && k <= 7) begin
        chk("stall_rdy", a_rdy, 0);
        chk("stall_vld", a_vld, 1);
        if (k == 4) begin
          hold_yr = a_yr; hold_yi = a_yi;
        end else begin
          chk("hold_yr", a_yr, hold_yr);
          chk("hold_yi", a_yi, hold_yi);
        end
      end
      acc = vld && a_rdy;
      @(posedge clk); #1;
      if (acc) idx++;
    end
    vld = 1'b0;
    chk("stream_accepted", idx, 10);

    // Random traffic with random backpressure.
    for (int k = 0; k < 400; k++) begin
      rdy_a = ($urandom_range(0, 9) < 7);
      if (!vld && $urandom_range(0, 3) != 0) begin
        set_rand();
        vld = 1'b1;
      end
      @(negedge clk);
      acc = vld && a_rdy;
      @(posedge clk); #1;
      if (acc) vld = 1'b0;
    end
    vld = 1'b0; rdy_a = 1'b1;
    repeat (8) begin @(posedge clk); #1; end
    chk("a_left", qa.size(), 0);
    chk("b_left", qb.size(), 0);
    chk("b_cnt_nonzero", b_cnt != 16'd0, 1);

    // Reset with three samples in flight.
    for (int k = 0; k < 3; k++) begin
      set_rand();
      vld = 1'b1;
      @(posedge clk); #1;
    end
    vld = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_vld", a_vld, 0);
    chk("mid_rst_cnt", a_cnt, 0);
    chk("mid_rst_sat", a_sat, 0);
    chk("mid_rst_yr", a_yr, 0);
    chk("mid_rst_b_vld", b_vld, 0);
    chk("mid_rst_b_cnt", b_cnt, 0);
    qa.delete(); qb.delete();
    cnt_a = 0; cnt_b = 0;
    @(negedge clk); rst = 1'b1;
    #1;
    chk("rel_rdy", a_rdy, 1);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("stale_a", a_vld, 0);
      chk("stale_b", b_vld, 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
